// File: rtl/mips_cpu_lsu.sv
// mips_cpu_lsu
//   Load/store unit sitting between the execute stage and a single-ported,
//   big-endian data memory that supports full-word writes only.
//   Sub-word stores are done as read-modify-write. LWL/LWR merge memory bytes
//   into the old rt value.
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/op/addr/wdata/rt_old request from execute; accepted when !busy
//   busy                           1 whenever a request is in flight
//   done_valid/done_rdata/done_err one-cycle completion pulse and result
//   data_address/read/write/writedata, data_readdata  memory port
module mips_cpu_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        busy,
    output logic        done_valid,
    output logic [31:0] done_rdata,
    output logic        done_err,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    localparam logic [3:0] OP_LB  = 4'h0;
    localparam logic [3:0] OP_LBU = 4'h1;
    localparam logic [3:0] OP_LH  = 4'h2;
    localparam logic [3:0] OP_LHU = 4'h3;
    localparam logic [3:0] OP_LW  = 4'h4;
    localparam logic [3:0] OP_LWL = 4'h5;
    localparam logic [3:0] OP_LWR = 4'h6;
    localparam logic [3:0] OP_SB  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ST_RD = 3'd2,
        S_ST_WR = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
            OP_SB, OP_SH, OP_SW: op_legal = 1'b1;
            default:             op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: op_is_load = 1'b1;
            default:                                             op_is_load = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] n);
        case (op)
            OP_LH, OP_LHU, OP_SH: misaligned = n[0];
            OP_LW, OP_SW:         misaligned = |n;
            default:              misaligned = 1'b0;
        endcase
    endfunction

    // Big-endian lane extraction: byte n lives at bits [31-8n -: 8].
    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] n,
                                                 input logic [31:0] mem, input logic [31:0] rt);
        logic [4:0]  sh_l;
        logic [4:0]  sh_r;
        logic [7:0]  b;
        logic [15:0] h;
        sh_l = {n, 3'b000};
        sh_r = 5'd24 - sh_l;
        b    = 8'(mem >> sh_r);
        h    = 16'(mem >> (n[1] ? 5'd0 : 5'd16));
        case (op)
            OP_LB:   load_extract = {{24{b[7]}}, b};
            OP_LBU:  load_extract = {24'h0, b};
            OP_LH:   load_extract = {{16{h[15]}}, h};
            OP_LHU:  load_extract = {16'h0, h};
            OP_LW:   load_extract = mem;
            OP_LWL:  load_extract = (mem << sh_l) | (rt & ((32'h1 << sh_l) - 32'h1));
            OP_LWR:  load_extract = (mem >> sh_r) | (rt & ~(32'hFFFF_FFFF >> sh_r));
            default: load_extract = 32'h0;
        endcase
    endfunction

    // Splice store data into the word read during ST_RD.
    function automatic logic [31:0] store_merge(input logic [3:0] op, input logic [1:0] n,
                                                input logic [31:0] mem, input logic [31:0] wd);
        logic [4:0] sh_b;
        logic [4:0] sh_h;
        sh_b = 5'd24 - {n, 3'b000};
        sh_h = n[1] ? 5'd0 : 5'd16;
        case (op)
            OP_SB:   store_merge = (mem & ~(32'h0000_00FF << sh_b)) | ({24'h0, wd[7:0]} << sh_b);
            OP_SH:   store_merge = (mem & ~(32'h0000_FFFF << sh_h)) | ({16'h0, wd[15:0]} << sh_h);
            default: store_merge = mem;
        endcase
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  op_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rt_old_r;
    logic        accept_s;
    logic [31:0] addr_src_s;
    logic        busy_s;
    logic        done_valid_s;
    logic        done_err_s;
    logic [31:0] done_rdata_s;
    logic [31:0] data_address_s;
    logic        data_read_s;
    logic        data_write_s;
    logic [31:0] data_writedata_s;

    assign accept_s = req_valid && (state_r == S_IDLE);

    // State and registered outputs; the output registers hold the memory-port
    // values for the state being entered, so the strobes line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_IDLE;
            busy           <= 1'b0;
            done_valid     <= 1'b0;
            done_err       <= 1'b0;
            done_rdata     <= 32'h0;
            data_address   <= 32'h0;
            data_read      <= 1'b0;
            data_write     <= 1'b0;
            data_writedata <= 32'h0;
        end else begin
            state_r        <= state_next_s;
            busy           <= busy_s;
            done_valid     <= done_valid_s;
            done_err       <= done_err_s;
            done_rdata     <= done_rdata_s;
            data_address   <= data_address_s;
            data_read      <= data_read_s;
            data_write     <= data_write_s;
            data_writedata <= data_writedata_s;
        end
    end

    // Request register: captured only on accept, frozen while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= 4'h0;
            addr_r   <= 32'h0;
            wdata_r  <= 32'h0;
            rt_old_r <= 32'h0;
        end else if (accept_s) begin
            op_r     <= req_op;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            rt_old_r <= req_rt_old;
        end else begin
            op_r     <= op_r;
            addr_r   <= addr_r;
            wdata_r  <= wdata_r;
            rt_old_r <= rt_old_r;
        end
    end

    // Next-state decode; the IDLE decision uses the live request inputs.
    always_comb begin
        state_next_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (!accept_s) begin
                    state_next_s = S_IDLE;
                end else if (!op_legal(req_op) || misaligned(req_op, req_addr[1:0])) begin
                    state_next_s = S_ERR;
                end else if (op_is_load(req_op)) begin
                    state_next_s = S_LOAD;
                end else if (req_op == OP_SW) begin
                    state_next_s = S_ST_WR;
                end else begin
                    state_next_s = S_ST_RD;
                end
            end
            S_LOAD:  state_next_s = S_IDLE;
            S_ST_RD: state_next_s = S_ST_WR;
            S_ST_WR: state_next_s = S_IDLE;
            S_ERR:   state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Next values of the output registers.
    always_comb begin
        addr_src_s   = (state_r == S_IDLE) ? req_addr : addr_r;
        busy_s       = (state_next_s != S_IDLE);
        done_valid_s = (state_r == S_LOAD) || (state_r == S_ST_WR) || (state_r == S_ERR);
        done_err_s   = (state_r == S_ERR);
        data_read_s  = (state_next_s == S_LOAD) || (state_next_s == S_ST_RD);
        data_write_s = (state_next_s == S_ST_WR);
        if (state_r == S_LOAD) begin
            done_rdata_s = load_extract(op_r, addr_r[1:0], data_readdata, rt_old_r);
        end else begin
            done_rdata_s = 32'h0;
        end
        if (data_read_s || data_write_s) begin
            data_address_s = {addr_src_s[31:2], 2'b00};
        end else begin
            data_address_s = 32'h0;
        end
        // SW goes straight from IDLE; SB/SH merge the word just read in ST_RD.
        if (!data_write_s) begin
            data_writedata_s = 32'h0;
        end else if (state_r == S_IDLE) begin
            data_writedata_s = req_wdata;
        end else begin
            data_writedata_s = store_merge(op_r, addr_r[1:0], data_readdata, wdata_r);
        end
    end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
module tb_mips_cpu_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rt_old;
    logic        busy;
    logic        done_valid;
    logic [31:0] done_rdata;
    logic        done_err;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    mips_cpu_lsu dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
        .busy(busy), .done_valid(done_valid), .done_rdata(done_rdata), .done_err(done_err),
        .data_address(data_address), .data_read(data_read), .data_write(data_write),
        .data_writedata(data_writedata), .data_readdata(data_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory window 0x1000..0x10FF: 64 words, combinational read, write at edge.
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        mem_clr;
    assign data_readdata = mem[data_address[7:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (data_write) begin
            mem[data_address[7:2]] <= data_writedata;
        end
    end

    int n_vec = 0;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model (byte-lane view) ----------------
    function automatic logic ref_bad(input logic [3:0] op, input logic [31:0] a);
        logic ill;
        logic mis;
        ill = (op == 4'd7) || (op > 4'd10);
        mis = ((op == 4'd2 || op == 4'd3 || op == 4'd9) && a[0]) ||
              ((op == 4'd4 || op == 4'd10) && (a[1:0] != 2'd0));
        return ill || mis;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input int n,
                                             input logic [31:0] m, input logic [31:0] rt);
        logic [7:0] by [4];
        logic [7:0] rb [4];
        logic [7:0] res [4];
        logic [15:0] h;
        for (int k = 0; k < 4; k++) begin
            by[k] = m[31 - 8 * k -: 8];
            rb[k] = rt[31 - 8 * k -: 8];
        end
        h = {by[2 * (n / 2)], by[2 * (n / 2) + 1]};
        case (op)
            4'd0: return {{24{by[n][7]}}, by[n]};
            4'd1: return {24'h0, by[n]};
            4'd2: return {{16{h[15]}}, h};
            4'd3: return {16'h0, h};
            4'd4: return m;
            4'd5: begin
                for (int k = 0; k < 4; k++) res[k] = (k + n <= 3) ? by[k + n] : rb[k];
                return {res[0], res[1], res[2], res[3]};
            end
            4'd6: begin
                for (int k = 0; k < 4; k++) res[k] = (k >= 3 - n) ? by[k - (3 - n)] : rb[k];
                return {res[0], res[1], res[2], res[3]};
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [3:0] op, input int n,
                                              input logic [31:0] m, input logic [31:0] wd);
        logic [7:0] by [4];
        for (int k = 0; k < 4; k++) by[k] = m[31 - 8 * k -: 8];
        if (op == 4'd8) begin
            by[n] = wd[7:0];
        end else if (op == 4'd9) begin
            by[2 * (n / 2)]     = wd[15:8];
            by[2 * (n / 2) + 1] = wd[7:0];
        end else begin
            return wd;
        end
        return {by[0], by[1], by[2], by[3]};
    endfunction

    // Outstanding request as predicted by the model.
    logic        pend = 1'b0;
    logic        chk_en = 1'b0;
    int          p_acc;
    int          p_lat = 2;
    logic        p_err, p_load, p_store, p_rmw;
    logic [31:0] p_rdata, p_wword, p_waddr;
    logic [5:0]  p_widx;

    // Per-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic int   d = cyc - p_acc;
            automatic logic e_busy = 1'b0, e_done = 1'b0, e_rd = 1'b0, e_wr = 1'b0;
            if (pend) begin
                e_busy = (d < p_lat - 1);
                e_done = (d == p_lat - 1);
                e_rd   = !p_err && (d == 0) && (p_load || p_rmw);
                e_wr   = !p_err && p_store && (d == p_lat - 2);
            end
            chk("busy", busy, e_busy);
            chk("done_valid", done_valid, e_done);
            chk("data_read", data_read, e_rd);
            chk("data_write", data_write, e_wr);
            if (e_rd || e_wr) chk("data_address", data_address, p_waddr);
            else              chk("data_address_idle", data_address, 32'h0);
            if (e_wr) chk("data_writedata", data_writedata, p_wword);
            else      chk("data_writedata_idle", data_writedata, 32'h0);
            if (e_done) begin
                chk("done_err", done_err, p_err);
                chk("done_rdata", done_rdata, p_rdata);
                chk("mem_word", mem[p_widx], ref_mem[p_widx]);
                pend = 1'b0;
            end
        end
    end

    task automatic junk(input logic v);
        req_valid  = v;
        req_op     = 4'($urandom_range(0, 15));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rt_old = $urandom;
    endtask

    // Apply one request, returning in its done cycle (DUT idle at the next edge).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rt, output logic [31:0] rd, output logic er);
        logic bad;
        req_op = op; req_addr = a; req_wdata = wd; req_rt_old = rt; req_valid = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        bad     = ref_bad(op, a);
        p_err   = bad;
        p_load  = !bad && (op <= 4'd6);
        p_store = !bad && (op >= 4'd8);
        p_rmw   = p_store && (op != 4'd10);
        p_lat   = p_rmw ? 3 : 2;
        p_waddr = {a[31:2], 2'b00};
        p_widx  = a[7:2];
        p_rdata = p_load ? ref_load(op, int'(a[1:0]), ref_mem[p_widx], rt) : 32'h0;
        p_wword = p_store ? ref_store(op, int'(a[1:0]), ref_mem[p_widx], wd) : 32'h0;
        if (p_store) ref_mem[p_widx] = p_wword;
        p_acc = cyc;
        pend  = 1'b1;
        // Requests offered while busy must be ignored.
        for (int i = 0; i < p_lat - 1; i++) begin
            junk(1'($urandom_range(0, 1)));
            @(posedge clk); #1;
        end
        rd = done_rdata;
        er = done_err;
        req_valid = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    logic [31:0] saved;

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        junk(1'b1);
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_done_err", done_err, 1'b0);
        chk("rst_done_rdata", done_rdata, 32'h0);
        chk("rst_data_read", data_read, 1'b0);
        chk("rst_data_write", data_write, 1'b0);
        chk("rst_data_address", data_address, 32'h0);
        chk("rst_data_writedata", data_writedata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; mem_clr = 1'b0; req_valid = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-computed results.
        issue(4'hA, 32'h1004, 32'h8899AABB, 32'h0, rd, er);
        issue(4'h0, 32'h1005, 32'h0, 32'h0, rd, er);        chk("lit_lb", rd, 32'hFFFFFF99);
        issue(4'h1, 32'h1005, 32'h0, 32'h0, rd, er);        chk("lit_lbu", rd, 32'h00000099);
        issue(4'h5, 32'h1005, 32'h0, 32'h11223344, rd, er); chk("lit_lwl", rd, 32'h99AABB44);
        issue(4'h6, 32'h1005, 32'h0, 32'h11223344, rd, er); chk("lit_lwr", rd, 32'h11228899);
        issue(4'h8, 32'h1006, 32'h000000EE, 32'h0, rd, er);
        chk("lit_sb_mem", mem[1], 32'h8899EEBB);
        chk("lit_sb_lat", 32'(cyc - p_acc), 32'd2);
        issue(4'h4, 32'h1006, 32'h0, 32'h0, rd, er);        chk("lit_lw_err", {31'h0, er}, 32'h1);
        issue(4'h9, 32'h1003, 32'h0, 32'h0, rd, er);        chk("lit_sh_err", {31'h0, er}, 32'h1);
        issue(4'hA, 32'h1000, 32'hCAFEF00D, 32'h0, rd, er); // next accepted in done cycle
        issue(4'h4, 32'h1000, 32'h0, 32'h0, rd, er);        chk("lit_b2b_lw", rd, 32'hCAFEF00D);

        // Randomized traffic, mixing back-to-back and idle gaps.
        for (int t = 0; t < 400; t++) begin
            automatic logic [3:0]  op = 4'($urandom_range(0, 15));
            automatic logic [31:0] a  = 32'h1000 + 32'($urandom_range(0, 255));
            issue(op, a, $urandom, $urandom, rd, er);
            repeat ($urandom_range(0, 2)) begin
                junk(1'b0);
                @(posedge clk); #1;
            end
        end

        // Reset while an SH sits in its read phase.
        @(posedge clk); #1;
        chk_en = 1'b0;
        saved = ref_mem[2];
        req_op = 4'h9; req_addr = 32'h100A; req_wdata = 32'h0000BEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        req_valid = 1'b0;
        chk("rmw_rd_phase", data_read, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rmw_rst_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("rmw_rst_write", data_write, 1'b0);
            chk("rmw_rst_done", done_valid, 1'b0);
            @(posedge clk); #1;
        end
        chk("rmw_rst_mem", mem[2], saved);

        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
